// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with a one-entry valid/ready holding register per output port.
// Optional per-port transfer counters are enabled by defining STREAM_DEMUX_XFER_CNT_EN.
module stream_demux #(
    parameter int N_OUTPUTS = 2,
    parameter int DWIDTH    = 8,
    parameter int CNT_WIDTH = 16,
    localparam int SW       = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DWIDTH-1:0]    in_data_i,
    input  logic [SW-1:0]        in_sel_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DWIDTH-1:0]    out_data_o [N_OUTPUTS],
    output logic [N_OUTPUTS-1:0] out_valid_o,
    input  logic [N_OUTPUTS-1:0] out_ready_i,
    output logic                 drop_err_o,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o [N_OUTPUTS]
);

    logic [DWIDTH-1:0]    outData_q  [N_OUTPUTS];
    logic [DWIDTH-1:0]    outData_d  [N_OUTPUTS];
    logic [N_OUTPUTS-1:0] outValid_q;
    logic [N_OUTPUTS-1:0] outValid_d;
    logic                 dropErr_q;
    logic                 dropErr_d;

    logic [N_OUTPUTS-1:0] portFree;
    logic [N_OUTPUTS-1:0] portDone;
    logic                 selInRange;
    logic                 selFree;
    logic                 accept;

    // A slot can take a new beat if empty or being drained this same cycle.
    assign portFree   = ~outValid_q | out_ready_i;
    assign portDone   = outValid_q & out_ready_i;
    assign selInRange = ({1'b0, in_sel_i} < (SW + 1)'(N_OUTPUTS));

    always_comb begin
        selFree = 1'b0;
        for (int p = 0; p < N_OUTPUTS; p++) begin
            if (in_sel_i == SW'(p)) begin
                selFree = portFree[p];
            end
        end
    end

    // Out-of-range destinations are always accepted so they can be discarded.
    assign in_ready_o = selInRange ? selFree : 1'b1;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        dropErr_d  = dropErr_q;
        for (int p = 0; p < N_OUTPUTS; p++) begin
            if (portDone[p]) begin
                outValid_d[p] = 1'b0;
            end
            if (accept && selInRange && (in_sel_i == SW'(p))) begin
                outValid_d[p] = 1'b1;
                outData_d[p]  = in_data_i;
            end
        end
        if (accept && !selInRange) begin
            dropErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outValid_q <= '0;
            dropErr_q  <= 1'b0;
            for (int p = 0; p < N_OUTPUTS; p++) begin
                outData_q[p] <= '0;
            end
        end else begin
            outValid_q <= outValid_d;
            dropErr_q  <= dropErr_d;
            for (int p = 0; p < N_OUTPUTS; p++) begin
                outData_q[p] <= outData_d[p];
            end
        end
    end

    assign out_data_o  = outData_q;
    assign out_valid_o = outValid_q;
    assign drop_err_o  = dropErr_q;

`ifdef STREAM_DEMUX_XFER_CNT_EN
    logic [CNT_WIDTH-1:0] xferCnt_q [N_OUTPUTS];
    logic [CNT_WIDTH-1:0] xferCnt_d [N_OUTPUTS];

    // Counters wrap naturally at the top of their range.
    always_comb begin
        for (int p = 0; p < N_OUTPUTS; p++) begin
            xferCnt_d[p] = xferCnt_q[p];
            if (portDone[p]) begin
                xferCnt_d[p] = xferCnt_q[p] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < N_OUTPUTS; p++) begin
            if (rst_i) begin
                xferCnt_q[p] <= '0;
            end else begin
                xferCnt_q[p] <= xferCnt_d[p];
            end
        end
    end

    assign xfer_cnt_o = xferCnt_q;
`else
    always_comb begin
        for (int p = 0; p < N_OUTPUTS; p++) begin
            xfer_cnt_o[p] = '0;
        end
    end
`endif

`ifdef SVA_ON
    for (genvar g = 0; g < N_OUTPUTS; g++) begin : gSva
        assert property (@(posedge clk_i) disable iff (rst_i)
            ($past(outValid_q[g] && !out_ready_i[g]) && !$past(rst_i))
                |-> (outData_q[g] == $past(outData_q[g])));
        assert property (@(posedge clk_i) disable iff (rst_i)
            ($past(outValid_q[g] && !out_ready_i[g]) && !$past(rst_i))
                |-> outValid_q[g]);
    end
    assert property (@(posedge clk_i) in_valid_i |-> !$isunknown(in_ready_o));
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-port instance for routing/backpressure/throughput,
// and a 3-port instance (CNT_WIDTH=4) for out-of-range drops, reset and counter wrap.
module tb_stream_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // 4-port instance
    logic        aRst;
    logic [7:0]  aInData;
    logic [1:0]  aInSel;
    logic        aInValid;
    logic        aInReady;
    logic [7:0]  aOutData [4];
    logic [3:0]  aOutValid;
    logic [3:0]  aOutReady;
    logic        aDropErr;
    logic [15:0] aXferCnt [4];

    stream_demux #(.N_OUTPUTS(4), .DWIDTH(8), .CNT_WIDTH(16)) dutA (
        .clk_i(clk), .rst_i(aRst), .in_data_i(aInData), .in_sel_i(aInSel),
        .in_valid_i(aInValid), .in_ready_o(aInReady), .out_data_o(aOutData),
        .out_valid_o(aOutValid), .out_ready_i(aOutReady), .drop_err_o(aDropErr),
        .xfer_cnt_o(aXferCnt)
    );

    // 3-port instance with narrow counters
    logic        bRst;
    logic [7:0]  bInData;
    logic [1:0]  bInSel;
    logic        bInValid;
    logic        bInReady;
    logic [7:0]  bOutData [3];
    logic [2:0]  bOutValid;
    logic [2:0]  bOutReady;
    logic        bDropErr;
    logic [3:0]  bXferCnt [3];

    stream_demux #(.N_OUTPUTS(3), .DWIDTH(8), .CNT_WIDTH(4)) dutB (
        .clk_i(clk), .rst_i(bRst), .in_data_i(bInData), .in_sel_i(bInSel),
        .in_valid_i(bInValid), .in_ready_o(bInReady), .out_data_o(bOutData),
        .out_valid_o(bOutValid), .out_ready_i(bOutReady), .drop_err_o(bDropErr),
        .xfer_cnt_o(bXferCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data, input logic valid);
        aInSel   = sel;
        aInData  = data;
        aInValid = valid;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        aRst = 1'b1; aInData = '0; aInSel = '0; aInValid = 1'b0; aOutReady = 4'b1111;
        bRst = 1'b1; bInData = '0; bInSel = '0; bInValid = 1'b0; bOutReady = 3'b111;
        tick();
        tick();
        aRst = 1'b0;
        bRst = 1'b0;

        checkOutput("rst_valid", 32'(aOutValid), 32'h0);
        checkOutput("rst_data2", 32'(aOutData[2]), 32'h0);
        checkOutput("rst_drop", 32'(aDropErr), 32'h0);
        checkOutput("rst_ready", 32'(aInReady), 32'h1);

        // Basic route to port 2
        applyStimulus(2'd2, 8'hA5, 1'b1);
        checkOutput("route_ready", 32'(aInReady), 32'h1);
        tick();
        applyStimulus(2'd0, 8'h00, 1'b0);
        checkOutput("route_valid", 32'(aOutValid), 32'h4);
        checkOutput("route_data", 32'(aOutData[2]), 32'hA5);
        tick();
        checkOutput("route_clear", 32'(aOutValid), 32'h0);

        // Backpressure on port 1
        aOutReady = 4'b1101;
        applyStimulus(2'd1, 8'h11, 1'b1);
        checkOutput("bp_ready0", 32'(aInReady), 32'h1);
        tick();
        applyStimulus(2'd1, 8'h22, 1'b1);
        checkOutput("bp_stall", 32'(aInReady), 32'h0);
        tick();
        checkOutput("bp_hold_data", 32'(aOutData[1]), 32'h11);
        checkOutput("bp_hold_valid", 32'(aOutValid), 32'h2);
        checkOutput("bp_still_stall", 32'(aInReady), 32'h0);
        aOutReady = 4'b1111;
        #1;
        checkOutput("bp_release_ready", 32'(aInReady), 32'h1);
        tick();
        applyStimulus(2'd0, 8'h00, 1'b0);
        checkOutput("bp_second_data", 32'(aOutData[1]), 32'h22);
        checkOutput("bp_second_valid", 32'(aOutValid), 32'h2);
        tick();
        checkOutput("bp_drain", 32'(aOutValid), 32'h0);

        // Port independence: port 0 stalled, port 3 still flows
        aOutReady = 4'b1110;
        applyStimulus(2'd0, 8'h33, 1'b1);
        tick();
        applyStimulus(2'd3, 8'h44, 1'b1);
        checkOutput("ind_ready3", 32'(aInReady), 32'h1);
        tick();
        applyStimulus(2'd0, 8'h00, 1'b0);
        checkOutput("ind_valid", 32'(aOutValid), 32'h9);
        checkOutput("ind_data3", 32'(aOutData[3]), 32'h44);
        checkOutput("ind_data0", 32'(aOutData[0]), 32'h33);
        aOutReady = 4'b1111;
        tick();
        checkOutput("ind_drain", 32'(aOutValid), 32'h0);

        // Back-to-back throughput on port 1
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'd1, 8'(i), 1'b1);
            checkOutput("tp_ready", 32'(aInReady), 32'h1);
            tick();
            checkOutput("tp_valid", 32'(aOutValid), 32'h2);
            checkOutput("tp_data", 32'(aOutData[1]), 32'(i));
        end
        applyStimulus(2'd0, 8'h00, 1'b0);
        tick();
        checkOutput("tp_drain", 32'(aOutValid), 32'h0);

        // Out-of-range destination on the 3-port instance
        bInSel = 2'd3; bInData = 8'hFF; bInValid = 1'b1;
        #1;
        checkOutput("oor_ready", 32'(bInReady), 32'h1);
        tick();
        bInValid = 1'b0;
        #1;
        checkOutput("oor_no_valid", 32'(bOutValid), 32'h0);
        checkOutput("oor_drop", 32'(bDropErr), 32'h1);
        tick();
        checkOutput("oor_sticky", 32'(bDropErr), 32'h1);

        // Hold a beat on port 2, then reset discards it
        bOutReady = 3'b011;
        bInSel = 2'd2; bInData = 8'h5A; bInValid = 1'b1;
        tick();
        bInValid = 1'b0;
        #1;
        checkOutput("held_valid", 32'(bOutValid), 32'h4);
        bRst = 1'b1;
        tick();
        bRst = 1'b0;
        bOutReady = 3'b111;
        #1;
        checkOutput("rstb_drop", 32'(bDropErr), 32'h0);
        checkOutput("rstb_valid", 32'(bOutValid), 32'h0);
        checkOutput("rstb_data2", 32'(bOutData[2]), 32'h0);

        // 17 completed transfers on port 0 wrap a 4-bit counter to 1
        bInSel = 2'd0; bInValid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bInData = 8'(i);
            tick();
        end
        bInValid = 1'b0;
        tick();
        checkOutput("cnt_valid_idle", 32'(bOutValid), 32'h0);
`ifdef STREAM_DEMUX_XFER_CNT_EN
        checkOutput("cnt_port0", 32'(bXferCnt[0]), 32'h1);
`else
        checkOutput("cnt_port0", 32'(bXferCnt[0]), 32'h0);
`endif
        checkOutput("cnt_port1", 32'(bXferCnt[1]), 32'h0);
        checkOutput("cnt_port2", 32'(bXferCnt[2]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer: the inverse of the N-to-1 select mux.
- Routes each accepted input beat, tagged with a destination index, to one of N output ports.
- Each output port has a one-entry holding register with valid/ready handshake.
- Used to fan one producer (e.g. a writeback or result stream) out to multiple consumers without combinational paths from input data to outputs.

Parameters:
- N_OUTPUTS, 2, number of output ports (>=2).
- DWIDTH, 8, data width in bits.
- CNT_WIDTH, 16, width of the optional per-port transfer counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DWIDTH  input beat data.
- in_sel  input  $clog2(N_OUTPUTS)  destination port index for the current beat.
- in_valid  input  1  input beat valid.
- in_ready  output  1  demux can accept the beat this cycle.
- out_data  output  [DWIDTH-1:0] x N_OUTPUTS (unpacked array)  per-port held data.
- out_valid  output  N_OUTPUTS  per-port data valid.
- out_ready  input  N_OUTPUTS  per-port consumer ready.
- drop_err  output  1  sticky flag: a beat with out-of-range in_sel was accepted.
- xfer_cnt  output  [CNT_WIDTH-1:0] x N_OUTPUTS  per-port completed-transfer count (optional feature).

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0 for all ports; out_data=0; drop_err=0; xfer_cnt=0.
  - Reset overrides any transfer in the same cycle. Reset mid-transfer discards held beats silently.
- Port p is "free" when out_valid[p]=0 or out_ready[p]=1.
- in_ready:
  - For in-range in_sel: in_ready = free(in_sel).
  - Combinational from in_sel, out_valid and out_ready only; no dependency on in_valid.
- Out-of-range in_sel (in_sel >= N_OUTPUTS, possible only when N_OUTPUTS is not a power of 2):
  - in_ready=1.
  - On accept, the beat is dropped, no out_valid changes, and drop_err is set to 1.
  - drop_err stays set until reset.
- Accept = in_valid && in_ready.
  - On accept to port s: out_data[s] <= in_data and out_valid[s] <= 1 at the next edge.
  - Latency: exactly 1 cycle from accept to out_valid.
- Output handshake: port p completes a transfer when out_valid[p] && out_ready[p].
  - On completion with no new accept to p: out_valid[p] <= 0.
  - Completion and accept to the same p in the same cycle: out_valid[p] stays 1 and out_data[p] is replaced with the new beat. This gives full throughput, 1 beat/cycle, to a single port.
- Ports are independent: holding or stalling on port p never blocks a beat destined for q != p.
- Data stability: while out_valid[p]=1 and out_ready[p]=0, out_data[p] must not change.
- in_data and in_sel are don't-care when in_valid=0. No state changes without accept or completion.
- Only one port can be written per cycle. Any number of ports may complete in the same cycle.
- Assertions (SVA_ON):
  - out_data stable under backpressure.
  - out_valid never drops without a handshake or reset.
  - in_ready known whenever in_valid=1.

Optional Feature:
- Macro: STREAM_DEMUX_XFER_CNT_EN.
- Defined:
  - xfer_cnt[p] increments by 1 on every completed output transfer on port p.
  - Wraps modulo 2^CNT_WIDTH (all-ones -> 0). Cleared by reset.
- Not defined: xfer_cnt ports remain present and are tied to 0; no counter flops are synthesized.

Test Plan:
- Basic route, N_OUTPUTS=4: in_sel=2, in_data=0xA5, in_valid=1 for 1 cycle, all out_ready=1 -> out_valid=4'b0100 with out_data[2]=0xA5 exactly 1 cycle later, cleared the cycle after; other ports untouched.
- Backpressure: out_ready[1]=0, send 0x11 then 0x22 to port 1 -> in_ready=0 while 0x11 is held, out_data[1]=0x11 stable. Raise out_ready[1] -> 0x11 completes and 0x22 is accepted the same cycle, appears next cycle.
- Independence: port 0 stalled holding 0x33, send 0x44 to port 3 -> accepted immediately, out_data[3]=0x44 next cycle, port 0 still holds 0x33.
- Throughput: 8 back-to-back beats 0x00..0x07 to port 1 with out_ready[1]=1 -> in_ready=1 every cycle, 8 consecutive out_valid cycles in order.
- Out-of-range, N_OUTPUTS=3: in_sel=3, in_data=0xFF -> in_ready=1, no out_valid asserted, drop_err=1 from next cycle until rst. Then rst=1 for 1 cycle -> drop_err=0 and out_valid=0, including a beat held at reset time.
- Counter (STREAM_DEMUX_XFER_CNT_EN, CNT_WIDTH=4): 17 completed transfers on port 0 -> xfer_cnt[0]=1 (wrapped), other counters 0. Without the macro -> all xfer_cnt=0.
